if_id_buffer: RTL and testbench

- IF→ID boundary register, directly downstream of the PC stage.
- Pairs each fetch address with its instruction word returned by the synchronous instruction ROM, which has 1-cycle read latency.
- Presents a stable {pc, inst, valid} to the ID stage.
- Owns an instruction hold register. During a stall the PC stage keeps presenting the next fetch address, so the live ROM output no longer belongs to the instruction sitting in ID; the hold register keeps that instruction.
- Handles flush (exception/ERET redirect) by inserting a bubble.

---
 rtl/if_id_buffer.sv | 96 +++++++++
 tb/tb_if_id_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF->ID boundary register: pairs each fetch address with its 1-cycle-latency ROM word.
// It holds the instruction across stalls and inserts a bubble on flush.
// Optional misaligned-fetch (AdEL) detection is enabled by defining IF_ADDR_EXC_EN.
module if_id_buffer #(
  parameter int unsigned                  ADDR_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]        NOP_INST   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  rom_en_i,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic                  id_valid,
  output logic                  id_exc_adel
);

  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic                  hold_valid_q, hold_valid_d;
`ifdef IF_ADDR_EXC_EN
  logic                  req_adel_q, req_adel_d;
`endif

  always_comb begin
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
`ifdef IF_ADDR_EXC_EN
    req_adel_d   = req_adel_q;
`endif
    if (flush) begin
      req_pc_d     = '0;
      req_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
`ifdef IF_ADDR_EXC_EN
      req_adel_d   = 1'b0;
`endif
    end else if (stall) begin
      // ROM data for the ID instruction is only on rom_rdata_i during the first stall cycle
      if (!hold_valid_q && req_valid_q) begin
        hold_inst_d  = rom_rdata_i;
        hold_valid_d = 1'b1;
      end
    end else begin
      req_pc_d     = pc_i;
      req_valid_d  = rom_en_i;
      hold_valid_d = 1'b0;
`ifdef IF_ADDR_EXC_EN
      req_adel_d   = rom_en_i & (pc_i[1:0] != 2'b00);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      hold_inst_q  <= '0;
      hold_valid_q <= 1'b0;
`ifdef IF_ADDR_EXC_EN
      req_adel_q   <= 1'b0;
`endif
    end else begin
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
`ifdef IF_ADDR_EXC_EN
      req_adel_q   <= req_adel_d;
`endif
    end
  end

  always_comb begin
    id_valid = req_valid_q;
    id_pc    = req_pc_q;
    if (hold_valid_q)     id_inst = hold_inst_q;
    else if (req_valid_q) id_inst = rom_rdata_i;
    else                  id_inst = NOP_INST;
`ifdef IF_ADDR_EXC_EN
    // Faulting fetch travels down as a valid NOP carrying the exception and BadVAddr
    id_exc_adel = req_adel_q & req_valid_q;
    if (id_exc_adel) id_inst = NOP_INST;
`else
    id_exc_adel = 1'b0;
`endif
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer with a synchronous 1-cycle ROM model and an
// expected-output scoreboard; covers streaming, stall, flush, async reset and AdEL.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_i = '0;
  logic        rom_en_i = 1'b0;
  logic [31:0] rom_rdata_i = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_exc_adel;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];

  if_id_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .pc_i(pc_i), .rom_en_i(rom_en_i), .rom_rdata_i(rom_rdata_i),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_exc_adel(id_exc_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_lookup(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h0000_0011;
      32'hBFC0_0004: return 32'h0000_0022;
      32'hBFC0_0008: return 32'h0000_0033;
      32'h0000_1000: return 32'h0000_AAAA;
      32'h0000_1004: return 32'h0000_BBBB;
      32'h0000_2000: return 32'h0000_CCCC;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  // Synchronous instruction ROM, one cycle read latency
  always @(posedge clk) begin
    if (rom_en_i) rom_rdata_i <= rom_lookup(pc_i);
  end

  task automatic drive(input logic s, input logic f, input logic en, input logic [31:0] pc);
    stall    = s;
    flush    = f;
    rom_en_i = en;
    pc_i     = pc;
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid, input logic adel, input string nm);
    exp_t e;
    e.pc = pc; e.inst = inst; e.valid = valid; e.adel = adel;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      if (id_pc !== e.pc) begin
        errors++;
        $display("FAIL %s id_pc got %h want %h", nm, id_pc, e.pc);
      end
      checks++;
      if (id_inst !== e.inst) begin
        errors++;
        $display("FAIL %s id_inst got %h want %h", nm, id_inst, e.inst);
      end
      checks++;
      if (id_valid !== e.valid) begin
        errors++;
        $display("FAIL %s id_valid got %b want %b", nm, id_valid, e.valid);
      end
      checks++;
      if (id_exc_adel !== e.adel) begin
        errors++;
        $display("FAIL %s id_exc_adel got %b want %b", nm, id_exc_adel, e.adel);
      end
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (id_pc !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0 || id_exc_adel !== 1'b0) begin
      errors++;
      $display("FAIL %s got pc=%h inst=%h valid=%b adel=%b want 0/0/0/0",
               nm, id_pc, id_inst, id_valid, id_exc_adel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'hBFC0_0000 + 32'(i * 4);
      drive(1'b0, 1'b0, 1'b1, a);
      expect_out(a, rom_lookup(a), 1'b1, 1'b0, "stream");
      tick();
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0500);
    expect_out(32'h0000_0500, 32'h0, 1'b0, 1'b0, "bubble_en0");
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0504);
    expect_out(32'h0000_0500, 32'h0, 1'b0, 1'b0, "stall_no_valid");
    tick();
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000);
    expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "pre_stall");
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_1004);
    for (int i = 0; i < 3; i++) begin
      expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "stall_hold");
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1004);
    expect_out(32'h0000_1004, 32'h0000_BBBB, 1'b1, 1'b0, "stall_release");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1008);
    expect_out(32'h0000_1008, 32'hDEAD_1008, 1'b1, 1'b0, "post_stall");
    tick();
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_2000);
    expect_out(32'h0000_2000, 32'h0000_CCCC, 1'b1, 1'b0, "pre_flush");
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_2004);
    expect_out(32'h0, 32'h0, 1'b0, 1'b0, "flush_bubble");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0180);
    expect_out(32'h8000_0180, 32'h5EAD_0180, 1'b1, 1'b0, "flush_target");
    tick();
  endtask

  task automatic test_flush_during_stall();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000);
    expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "fs_pre");
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_1004);
    expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "fs_stall");
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1004);
    expect_out(32'h0, 32'h0, 1'b0, 1'b0, "fs_flush");
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_1004);
    expect_out(32'h0, 32'h0, 1'b0, 1'b0, "fs_still_stalled");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1004);
    expect_out(32'h0000_1004, 32'h0000_BBBB, 1'b1, 1'b0, "fs_resume");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1008);
    expect_out(32'h0000_1008, 32'hDEAD_1008, 1'b1, 1'b0, "fs_resume2");
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000);
    expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "ar_pre");
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_1004);
    expect_out(32'h0000_1000, 32'h0000_AAAA, 1'b1, 1'b0, "ar_stall");
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_immediate");
    @(posedge clk);
    #1;
    check_reset_outputs("async_reset_held");
    rst = 1'b0;
    test_streaming();
  endtask

  task automatic test_adel();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3002);
`ifdef IF_ADDR_EXC_EN
    expect_out(32'h0000_3002, 32'h0, 1'b1, 1'b1, "adel_misaligned");
`else
    expect_out(32'h0000_3002, 32'hDEAD_3002, 1'b1, 1'b0, "adel_misaligned");
`endif
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3004);
    expect_out(32'h0000_3004, 32'hDEAD_3004, 1'b1, 1'b0, "adel_aligned");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_bubble();
    test_stall();
    test_flush();
    test_flush_during_stall();
    test_async_reset();
    test_adel();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
